// File: rtl/snitch_tcdm_bank_arbiter.sv
// snitch_tcdm_bank_arbiter: round-robin arbiter of NumReq TCDM ports onto one SRAM bank,
// routing each response back to its issuer through the bank's fixed read latency.
module snitch_tcdm_bank_arbiter #(
  parameter int unsigned NumReq                = 4,
  parameter int unsigned PayloadWidth          = 72,
  parameter int unsigned DataWidth             = 64,
  parameter int unsigned MemoryResponseLatency = 1,
  parameter int unsigned CntWidth              = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*PayloadWidth-1:0] req_payload_i,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic [PayloadWidth-1:0]        mem_payload_o,
  input  logic [DataWidth-1:0]           mem_rsp_data_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_data_o,
  output logic [CntWidth-1:0]            conflict_cnt_o,
  input  logic                           cnt_clr_i
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned Lat  = MemoryResponseLatency;
  logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt, cand;
  logic            lock_q, lock_d, hs;
  logic [Lat-1:0]  vld_q, vld_d;
  logic [IdxW-1:0] idx_q [Lat];
  logic [IdxW-1:0] idx_d [Lat];
  logic [CntWidth-1:0] cnt_q, cnt_d;
  // Descending search so the candidate closest to rr_q is assigned last and wins.
  always_comb begin
    gnt  = lock_idx_q;
    cand = '0;
    if (!lock_q) begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        cand = IdxW'((int'(rr_q) + k) % NumReq);
        if (req_valid_i[cand]) gnt = cand;
      end
    end
  end
  assign mem_valid_o    = |req_valid_i;
  assign hs             = mem_valid_o & mem_ready_i;
  assign req_ready_o    = hs ? (NumReq'(1) << gnt) : '0;
  assign mem_payload_o  = req_payload_i[gnt*PayloadWidth +: PayloadWidth];
  assign rsp_valid_o    = vld_q[Lat-1] ? (NumReq'(1) << idx_q[Lat-1]) : '0;
  assign rsp_data_o     = mem_rsp_data_i;
  assign conflict_cnt_o = cnt_q;
  always_comb begin
    rr_d       = hs ? ((int'(gnt) == NumReq - 1) ? '0 : gnt + 1'b1) : rr_q;
    lock_d     = mem_valid_o & ~mem_ready_i;
    lock_idx_d = (mem_valid_o & ~mem_ready_i) ? gnt : lock_idx_q;
    cnt_d      = cnt_clr_i ? '0 : (($countones(req_valid_i) >= 2) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    vld_d[0]   = hs;
    idx_d[0]   = gnt;
    for (int s = 1; s < Lat; s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      vld_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
    end
  end
  // Indices are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk_i) idx_q <= idx_d;
endmodule

// File: doc/snitch_tcdm_bank_arbiter.md
Name: snitch_tcdm_bank_arbiter

Overview:
- Arbitrates NumReq TCDM requesters onto one SRAM bank port using round-robin priority.
- Holds the grant stable under back-pressure and tracks the grant index through the bank's fixed read latency, so each response returns to the requester that issued it.
- Sits between core/DMA ports and a single bank macro, for clusters that use per-bank arbitration instead of a full crossbar.
- Also counts conflict cycles for performance monitoring.

Parameters:
- NumReq, 4: number of requesters; must be ≥ 2.
- PayloadWidth, 72: width of the request payload (addr/write/data/strb/user, packed); routed opaquely.
- DataWidth, 64: width of response data.
- MemoryResponseLatency, 1: cycles from bank handshake to response data; must be ≥ 1.
- CntWidth, 16: width of the conflict counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester grant (handshake = valid & ready).
- req_payload_i  in  NumReq*PayloadWidth  requester payloads; requester i occupies bits [i*PayloadWidth +: PayloadWidth].
- mem_valid_o  out  1  request to bank.
- mem_ready_i  in  1  bank accepts.
- mem_payload_o  out  PayloadWidth  payload of the granted requester.
- mem_rsp_data_i  in  DataWidth  bank read data, valid MemoryResponseLatency cycles after handshake.
- rsp_valid_o  out  NumReq  one-hot response valid.
- rsp_data_o  out  DataWidth  response data, broadcast to all requesters.
- conflict_cnt_o  out  CntWidth  saturating count of cycles with ≥ 2 valid requesters.
- cnt_clr_i  in  1  synchronous clear of the conflict counter.

Behaviour:
- State:
  - rr_q: priority pointer, clog2(NumReq) bits.
  - lock_q and lock_idx_q: grant lock.
  - Response pipeline: MemoryResponseLatency stages of {valid, idx}.
  - cnt_q: conflict counter.
- Reset (rst_ni low at a clock edge): rr_q=0, lock_q=0, all pipeline stages invalid, cnt_q=0.
- Outputs during and after reset:
  - rsp_valid_o=0 for MemoryResponseLatency cycles after reset.
  - mem_valid_o follows req_valid_i combinationally even in reset.
  - req_ready_o=0 whenever mem_ready_i=0.
- Arbitration is combinational, zero latency:
  - If lock_q=1: grant lock_idx_q.
  - Else: grant the first i with req_valid_i[i]=1, searching rr_q, rr_q+1, … mod NumReq.
  - mem_valid_o = |req_valid_i.
  - mem_payload_o = payload of the granted requester; don't-care when mem_valid_o=0.
  - req_ready_o[g] = mem_ready_i for the granted g; all other bits 0.
- Lock-in:
  - If mem_valid_o=1 and mem_ready_i=0: lock_q<=1, lock_idx_q<=g.
  - Cleared on the handshake cycle.
  - A requester must not drop valid or change payload while unacknowledged; the bench asserts this. A lock never switches requester.
- Pointer update: on handshake with granted g, rr_q <= (g+1) mod NumReq. No update without a handshake.
- Fairness: a continuously valid requester is granted within NumReq handshakes.
- Response tracking:
  - Stage 0 captures {handshake, g} every cycle.
  - The shift register advances unconditionally; the bank has no response back-pressure.
  - After MemoryResponseLatency cycles: rsp_valid_o[idx]=1 if the stage valid bit is set; rsp_data_o = mem_rsp_data_i passed through combinationally.
  - Responses are produced for writes too (valid only; data don't-care).
- Throughput: one handshake per cycle; back-to-back grants to the same requester are allowed when it is the only one valid.
- Conflict counter:
  - Increments when popcount(req_valid_i) ≥ 2.
  - Saturates at all-ones; no wrap.
  - cnt_clr_i has priority over increment: counter = 0 the next cycle.
- Reset mid-operation: in-flight responses are dropped and no rsp_valid_o is generated for them. The lock and pointer are discarded.
- NumReq not a power of two: pointer wrap uses mod NumReq, never indexing ≥ NumReq.

Test Plan:
- Single requester, Latency=1: req 2 valid 3 consecutive cycles, mem_ready_i=1 → req_ready_o[2]=1 each cycle; rsp_valid_o=4'b0100 cycles 1–3 with matching data.
- All 4 valid continuously after reset, ready=1 → grant order 0,1,2,3,0,…; conflict_cnt_o increments by 1 per cycle.
- Back-pressure: req 1 and 3 valid, rr_q=3, mem_ready_i=0 for 3 cycles → grant stays 3, payload stable. Ready rises → handshake to 3, next grant 1.
- Latency=3: handshakes to 0,2,1 on consecutive cycles → rsp_valid_o one-hot 0001,0100,0010 exactly 3 cycles after each.
- Reset asserted 1 cycle after a handshake with Latency=2 → no rsp_valid_o pulse. rr_q=0, so next grant among {1,3} is 1.
- CntWidth=4, 2 requesters valid for 20 cycles → counter saturates at 15. cnt_clr_i together with a conflict → 0 next cycle.
